// File: rtl/aes_ctr_defs.sv
// Shared definitions for the AES-CTR keystream controller: FSM encodings and
// the default width of the incrementing counter field.
package aes_ctr_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'h0,
        ST_START = 2'h1,
        ST_WAIT  = 2'h2,
        ST_DRAIN = 2'h3
    } ctr_state_e;

    localparam int CTR_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/aes_ctr_inc.sv
// Counter-block incrementer: bumps the low CTR_WIDTH bits modulo 2^CTR_WIDTH,
// upper bits pass through untouched (no carry out of the counter field).
module aes_ctr_inc
    import aes_ctr_defs::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic [127:0] blk_i,
    output logic [127:0] blk_o
);

    if (CTR_WIDTH >= 128) begin : g_full
        assign blk_o = blk_i + 128'd1;
    end else begin : g_part
        assign blk_o = {blk_i[127:CTR_WIDTH], blk_i[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};
    end

endmodule

// File: rtl/aes_ctr_stream.sv
// CTR-mode keystream controller around an AES encipher core. Define
// AES_CTR_PREFETCH_EN to compute the next keystream block speculatively.
module aes_ctr_stream
    import aes_ctr_defs::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         core_next,
    output logic [127:0] core_block,
    input  logic [127:0] core_result,
    input  logic         core_ready,
    output logic         busy
);

    ctr_state_e   state_q;
    logic [127:0] ctr_q, ctr_d;
    logic [127:0] ks_q;
    logic         ks_vld_q;
    logic [127:0] out_q;
    logic         out_vld_q;
    logic         loaded_q;
    logic         core_next_q;
    logic         busy_q;
    logic         gen_req;
    logic         in_xfer;
    logic         out_xfer;

`ifdef AES_CTR_PREFETCH_EN
    assign gen_req = 1'b1;
`else
    assign gen_req = in_valid;
`endif

    aes_ctr_inc #(.CTR_WIDTH(CTR_WIDTH)) u_inc (
        .blk_i (ctr_q),
        .blk_o (ctr_d)
    );

    assign in_ready   = ks_vld_q & (~out_vld_q | out_ready) & ~init;
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_vld_q & out_ready;
    assign out_valid  = out_vld_q;
    assign out_data   = out_q;
    assign core_next  = core_next_q;
    assign core_block = ctr_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            ks_q        <= '0;
            ks_vld_q    <= 1'b0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            loaded_q    <= 1'b0;
            core_next_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (init) begin
            ctr_q       <= iv;
            loaded_q    <= 1'b1;
            ks_vld_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            core_next_q <= 1'b0;
            // A block already handed to the core must be waited out and dropped.
            if (state_q == ST_START || state_q == ST_WAIT) begin
                state_q <= ST_DRAIN;
                busy_q  <= 1'b1;
            end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            core_next_q <= 1'b0;
            if (in_xfer) begin
                out_q     <= in_data ^ ks_q;
                out_vld_q <= 1'b1;
                ks_vld_q  <= 1'b0;
            end else if (out_xfer) begin
                out_vld_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (loaded_q && !ks_vld_q && core_ready && gen_req) begin
                        state_q     <= ST_START;
                        core_next_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_START: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (core_ready) begin
                        ks_q     <= core_result;
                        ks_vld_q <= 1'b1;
                        ctr_q    <= ctr_d;
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (core_ready) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Scoreboard bench for aes_ctr_stream with a behavioural AES core stand-in that
// returns the NIST SP800-38A F.5.1 keystream blocks for the two reference counters.
module tb_aes_ctr_stream;

    localparam int CORE_LAT = 4;

    localparam logic [127:0] NIST_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] NIST_IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] NIST_KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] NIST_KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;
    localparam logic [127:0] NIST_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] NIST_C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] NIST_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] NIST_C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] WRAP_IV  = 128'h00112233445566778899aabbffffffff;
    localparam logic [127:0] WRAP_IV2 = 128'h00112233445566778899aabb00000000;
    localparam logic [127:0] BP_IV    = 128'hcafef00d000000001234567800000010;
    localparam logic [127:0] BP_IV2   = 128'hcafef00d000000001234567800000011;
    localparam logic [127:0] DR_OLD   = 128'h11112222333344445555666677778888;
    localparam logic [127:0] DR_NEW   = 128'h0f0e0d0c0b0a09080706050400000100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         init = 1'b0;
    logic [127:0] iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         core_next;
    logic [127:0] core_block;
    logic [127:0] core_result;
    logic         core_ready;
    logic         busy;

    int           checks = 0;
    int           failures = 0;
    int           nxt_cnt = 0;
    int           out_idx = 0;
    logic [127:0] exp_q[$];
    logic [127:0] blk_log[$];
    logic [127:0] mon_exp;

    int           core_cnt;
    logic [127:0] core_blk;

    always #5 clk = ~clk;

    aes_ctr_stream dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .init        (init),
        .iv          (iv),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .core_next   (core_next),
        .core_block  (core_block),
        .core_result (core_result),
        .core_ready  (core_ready),
        .busy        (busy)
    );

    function automatic logic [127:0] ks_fn(input logic [127:0] b);
        if (b == NIST_IV)  return NIST_KS1;
        if (b == NIST_IV2) return NIST_KS2;
        return {b[63:0], b[127:64]} ^ 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    endfunction

    // Core stand-in: ready drops the cycle after next, result appears CORE_LAT cycles later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready  <= 1'b1;
            core_result <= '0;
            core_cnt    <= 0;
            core_blk    <= '0;
        end else if (core_next) begin
            core_ready <= 1'b0;
            core_cnt   <= CORE_LAT;
            core_blk   <= core_block;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_ready  <= 1'b1;
                core_result <= ks_fn(core_blk);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (core_next) begin
                checks++;
                if (!core_ready) begin
                    failures++;
                    $display("FAIL core_next_while_busy actual core_ready=%0b required=1", core_ready);
                end
                blk_log.push_back(core_block);
                nxt_cnt++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=<none>", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        failures++;
                        $display("FAIL out_data[%0d] actual=%h required=%h", out_idx, out_data, mon_exp);
                    end
                end
                out_idx++;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [127:0] exp);
        checks++;
        if (idx >= blk_log.size()) begin
            failures++;
            $display("FAIL %s actual=<no block %0d> required=%h", nm, idx, exp);
        end else if (blk_log[idx] !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, blk_log[idx], exp);
        end
    endtask

    task automatic do_init(input logic [127:0] v);
        init = 1'b1;
        iv   = v;
        @(posedge clk); #1;
        init = 1'b0;
        blk_log.delete();
        nxt_cnt = 0;
    endtask

    task automatic accept(input string nm);
        int n = 0;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout actual in_ready=0 required=1", nm);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input string nm, input logic [127:0] d, input logic [127:0] e);
        exp_q.push_back(e);
        in_data = d;
        accept(nm);
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_drained"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_next(input string nm);
        int n = 0;
        while (nxt_cnt == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_core_next_seen"}, 128'(nxt_cnt != 0), 128'd1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"},   128'(in_ready),   128'd0);
        chk({nm, "_out_valid"},  128'(out_valid),  128'd0);
        chk({nm, "_out_data"},   out_data,         128'd0);
        chk({nm, "_core_next"},  128'(core_next),  128'd0);
        chk({nm, "_core_block"}, core_block,       128'd0);
        chk({nm, "_busy"},       128'(busy),       128'd0);
    endtask

    task automatic bp_watch();
        int           n = 0;
        logic [127:0] held;
        bit           stable = 1'b1;
        bit           blocked = 1'b1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_first_valid", 128'(out_valid), 128'd1);
        held = out_data;
        chk("bp_first_data", held, 128'h8888888888888888_3333333333333333 ^ ks_fn(BP_IV));
        repeat (50) begin
            @(negedge clk);
            if (out_data !== held || !out_valid) stable = 1'b0;
            if (in_ready) blocked = 1'b0;
        end
        chk("bp_out_stable", 128'(stable), 128'd1);
        chk("bp_in_ready_low", 128'(blocked), 128'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Nothing may start before the first init.
        in_data  = 128'h1;
        in_valid = 1'b1;
        repeat (20) @(posedge clk); #1;
        in_valid = 1'b0;
        chk("no_start_before_init", 128'(nxt_cnt), 128'd0);

        do_init(NIST_IV);
        repeat (20) @(posedge clk); #1;
`ifdef AES_CTR_PREFETCH_EN
        chk("prefetch_after_init", 128'(nxt_cnt), 128'd1);
`else
        chk("no_prefetch_after_init", 128'(nxt_cnt), 128'd0);
`endif
        send("nist1", NIST_P1, NIST_C1);
        send("nist2", NIST_P2, NIST_C2);
        wait_empty("nist");
        chk_log("nist_block0", 0, NIST_IV);
        chk_log("nist_block1", 1, NIST_IV2);

        do_init(WRAP_IV);
        send("wrap1", 128'hdeadbeef, 128'hdeadbeef ^ ks_fn(WRAP_IV));
        send("wrap2", 128'hfeedface, 128'hfeedface ^ ks_fn(WRAP_IV2));
        wait_empty("wrap");
        chk_log("wrap_block0", 0, WRAP_IV);
        chk_log("wrap_block1", 1, WRAP_IV2);

        out_ready = 1'b0;
        do_init(BP_IV);
        fork
            begin
                send("bp1", 128'h8888888888888888_3333333333333333,
                     128'h8888888888888888_3333333333333333 ^ ks_fn(BP_IV));
                send("bp2", 128'h0123456789abcdef_fedcba9876543210,
                     128'h0123456789abcdef_fedcba9876543210 ^ ks_fn(BP_IV2));
            end
            bp_watch();
        join
        wait_empty("bp");

        // init while the core is working: that result must be dropped.
        do_init(DR_OLD);
        in_data  = 128'h00000000ffffffff00000000ffffffff;
        in_valid = 1'b1;
        wait_next("drain");
        init = 1'b1;
        iv   = DR_NEW;
        @(posedge clk); #1;
        init = 1'b0;
        blk_log.delete();
        nxt_cnt = 0;
        chk("drain_busy", 128'(busy), 128'd1);
        exp_q.push_back(128'h00000000ffffffff00000000ffffffff ^ ks_fn(DR_NEW));
        accept("drain");
        wait_empty("drain");
        chk_log("drain_new_block", 0, DR_NEW);

        // Reset in the middle of a core operation.
        do_init(128'h5555aaaa5555aaaa5555aaaa00000007);
        in_data  = 128'h77;
        in_valid = 1'b1;
        wait_next("rst");
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        nxt_cnt = 0;
        repeat (30) @(posedge clk); #1;
        in_valid = 1'b0;
        chk("no_start_after_reset", 128'(nxt_cnt), 128'd0);
        chk("final_scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
